// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the debug hex display controller.
// Index constants follow the DCPU-16 register numbering.
package hex_disp_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned NUM_REGS_DEF = 12;
   localparam int unsigned DWELL_DEF    = 50_000_000;
   localparam int unsigned IDX_W_DEF    = 4;

   typedef logic [IDX_W_DEF-1:0] idx_t;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_t;

   localparam idx_t IDX_A  = idx_t'(0);
   localparam idx_t IDX_B  = idx_t'(1);
   localparam idx_t IDX_C  = idx_t'(2);
   localparam idx_t IDX_X  = idx_t'(3);
   localparam idx_t IDX_Y  = idx_t'(4);
   localparam idx_t IDX_Z  = idx_t'(5);
   localparam idx_t IDX_I  = idx_t'(6);
   localparam idx_t IDX_J  = idx_t'(7);
   localparam idx_t IDX_PC = idx_t'(8);
   localparam idx_t IDX_SP = idx_t'(9);
   localparam idx_t IDX_EX = idx_t'(10);
   localparam idx_t IDX_IA = idx_t'(11);

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level followed by a
// rising-edge detector; pulse_c is high for one cycle per press.
module btn_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic pulse_c
);

   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         prev_q <= sync_q[1];
      end
   end

   // Decoded from flops only, so it is glitch-free for the consumer.
   assign pulse_c = sync_q[1] & ~prev_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Snapshot buffer of CPU debug words with auto/manual selection, driving
// four registered nibbles and per-digit blank flags to the hex decoders.
module hex_display_ctrl
   import hex_disp_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned DWELL    = DWELL_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              auto_en,
   input  logic              step,
   input  logic              freeze,
   output logic [3:0]        nib0,
   output logic [3:0]        nib1,
   output logic [3:0]        nib2,
   output logic [3:0]        nib3,
   output logic [3:0]        blank,
   output logic [IDX_W-1:0]  sel_idx
);

   localparam int unsigned      CNT_W    = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   logic [DATA_W-1:0]   entry_q [NUM_REGS];
   logic [NUM_REGS-1:0] written_q;
   logic [IDX_W-1:0]    sel_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                step_pulse_c;
   logic [IDX_W-1:0]    sel_next_c;
   mode_t               mode_c;

   btn_edge_sync u_step_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (step),
      .pulse_c (step_pulse_c)
   );

   // Explicit wrap so non-power-of-two buffer sizes never index past the end.
   assign sel_next_c = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
   assign mode_c     = auto_en ? MODE_AUTO : MODE_MANUAL;
   assign sel_idx    = sel_q;

   // Snapshot buffer; out-of-range indices are dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            entry_q[i] <= '0;
         end
         written_q <= '0;
      end else if (wr_en && (wr_idx <= LAST_IDX)) begin
         entry_q[wr_idx]   <= wr_data;
         written_q[wr_idx] <= 1'b1;
      end
   end

   // Selection state: manual stepping or dwell-timed auto cycling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= '0;
         cnt_q <= '0;
      end else if (!freeze) begin
         case (mode_c)
            MODE_MANUAL: begin
               cnt_q <= '0;
               if (step_pulse_c) begin
                  sel_q <= sel_next_c;
               end
            end
            MODE_AUTO: begin
               // A press on the terminal-count edge still advances only once.
               if (step_pulse_c || (cnt_q == LAST_CNT)) begin
                  sel_q <= sel_next_c;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               sel_q <= '0;
               cnt_q <= '0;
            end
         endcase
      end
   end

   // Display register, loaded from the entry selected before this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nib0  <= 4'h0;
         nib1  <= 4'h0;
         nib2  <= 4'h0;
         nib3  <= 4'h0;
         blank <= 4'b1111;
      end else if (!freeze) begin
         {nib3, nib2, nib1, nib0} <= entry_q[sel_q];
         blank                    <= written_q[sel_q] ? 4'b0000 : 4'b1111;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised self-checking bench for hex_display_ctrl (12 entries, dwell 4).
module tb_hex_display_ctrl;

   localparam int N  = 12;
   localparam int DW = 4;

   logic        clk;
   logic        reset_n;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [15:0] wr_data;
   logic        auto_en;
   logic        step;
   logic        freeze;
   logic [3:0]  nib0, nib1, nib2, nib3;
   logic [3:0]  blank;
   logic [3:0]  sel_idx;
   logic [15:0] disp;

   logic [15:0] model_buf [N];
   bit          model_wr  [N];
   int          model_sel;
   int          compares;
   int          mismatches;

   hex_display_ctrl #(.NUM_REGS(N), .DWELL(DW), .IDX_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .auto_en (auto_en),
      .step    (step),
      .freeze  (freeze),
      .nib0    (nib0),
      .nib1    (nib1),
      .nib2    (nib2),
      .nib3    (nib3),
      .blank   (blank),
      .sel_idx (sel_idx)
   );

   assign disp = {nib3, nib2, nib1, nib0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         model_buf[i] = 16'h0000;
         model_wr[i]  = 1'b0;
      end
      model_sel = 0;
   endtask

   // One write strobe lasting exactly one edge; model ignores bad indices.
   task automatic do_write(input int idx, input logic [15:0] data);
      wr_en   = 1'b1;
      wr_idx  = 4'(idx);
      wr_data = data;
      tick();
      wr_en = 1'b0;
      if (idx < N) begin
         model_buf[idx] = data;
         model_wr[idx]  = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      clear_model();
      compares++;
      if (blank !== 4'b1111) begin
         mismatches++;
         $display("FAIL reset_blank: got %b expected 1111", blank);
      end
      compares++;
      if (disp !== 16'h0000) begin
         mismatches++;
         $display("FAIL reset_nibs: got %h expected 0000", disp);
      end
      compares++;
      if (sel_idx !== 4'd0) begin
         mismatches++;
         $display("FAIL reset_sel: got %0d expected 0", sel_idx);
      end
      tick();
      compares++;
      if (blank !== 4'b1111) begin
         mismatches++;
         $display("FAIL reset_unwritten_blank: got %b expected 1111", blank);
      end
   endtask

   task automatic test_write_display();
      do_write(0, 16'hBEEF);
      compares++;
      if (blank !== 4'b1111 || disp !== 16'h0000) begin
         mismatches++;
         $display("FAIL write_too_early: got %h/%b expected 0000/1111", disp, blank);
      end
      tick();
      compares++;
      if (disp !== 16'hBEEF) begin
         mismatches++;
         $display("FAIL write_display_nibs: got %h expected beef", disp);
      end
      compares++;
      if (blank !== 4'b0000) begin
         mismatches++;
         $display("FAIL write_display_blank: got %b expected 0000", blank);
      end
   endtask

   task automatic test_invalid_write();
      for (int idx = N; idx < 16; idx++) begin
         do_write(idx, 16'h1234);
      end
      tick();
      compares++;
      if (disp !== model_buf[model_sel] || blank !== 4'b0000 || sel_idx !== 4'(model_sel)) begin
         mismatches++;
         $display("FAIL invalid_write: got %h/%b/%0d expected %h/0000/%0d",
                  disp, blank, sel_idx, model_buf[model_sel], model_sel);
      end
   endtask

   // Auto cycling across all entries with known contents.
   task automatic test_auto_cycle();
      int s0;
      int e;
      int len;
      logic [3:0] exp_blank;
      for (int i = 0; i < N; i++) begin
         do_write(i, 16'h0100 + 16'(i));
      end
      tick();
      s0  = model_sel;
      len = 2 * N * DW + 5;
      auto_en = 1'b1;
      for (int n = 1; n <= len; n++) begin
         tick();
         e = (s0 + (n - 1) / DW) % N;
         exp_blank = model_wr[e] ? 4'b0000 : 4'b1111;
         compares++;
         if (sel_idx !== 4'((s0 + n / DW) % N)) begin
            mismatches++;
            $display("FAIL auto_sel n=%0d: got %0d expected %0d", n, sel_idx, (s0 + n / DW) % N);
         end
         compares++;
         if (disp !== model_buf[e] || blank !== exp_blank) begin
            mismatches++;
            $display("FAIL auto_disp n=%0d: got %h/%b expected %h/%b",
                     n, disp, blank, model_buf[e], exp_blank);
         end
      end
      auto_en = 1'b0;
      tick();
      model_sel = (s0 + len / DW) % N;
   endtask

   // Step press whose detected pulse lands on the terminal-count edge.
   task automatic test_step_terminal();
      int s;
      s = model_sel;
      auto_en = 1'b1;
      tick();
      step = 1'b1;
      tick();
      tick();
      compares++;
      if (sel_idx !== 4'(s)) begin
         mismatches++;
         $display("FAIL step_tc_early: got %0d expected %0d", sel_idx, s);
      end
      tick();
      step = 1'b0;
      compares++;
      if (sel_idx !== 4'((s + 1) % N)) begin
         mismatches++;
         $display("FAIL step_tc_advance: got %0d expected %0d", sel_idx, (s + 1) % N);
      end
      tick();
      tick();
      tick();
      compares++;
      if (sel_idx !== 4'((s + 1) % N)) begin
         mismatches++;
         $display("FAIL step_tc_hold: got %0d expected %0d", sel_idx, (s + 1) % N);
      end
      tick();
      compares++;
      if (sel_idx !== 4'((s + 2) % N)) begin
         mismatches++;
         $display("FAIL step_tc_next: got %0d expected %0d", sel_idx, (s + 2) % N);
      end
      auto_en = 1'b0;
      tick();
      model_sel = (s + 2) % N;
   endtask

   task automatic test_step_held();
      int s;
      s = model_sel;
      step = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      compares++;
      if (sel_idx !== 4'((s + 1) % N)) begin
         mismatches++;
         $display("FAIL step_held_high: got %0d expected %0d", sel_idx, (s + 1) % N);
      end
      step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      compares++;
      if (sel_idx !== 4'((s + 1) % N)) begin
         mismatches++;
         $display("FAIL step_held_release: got %0d expected %0d", sel_idx, (s + 1) % N);
      end
      model_sel = (s + 1) % N;
   endtask

   // Freeze in auto mode with a dropped press and a write to the shown entry.
   task automatic test_freeze();
      int s;
      logic [15:0] old_val;
      logic [3:0]  old_blank;
      logic [15:0] new_val;
      s         = model_sel;
      old_val   = model_buf[s];
      old_blank = model_wr[s] ? 4'b0000 : 4'b1111;
      new_val   = 16'($urandom);
      auto_en = 1'b1;
      tick();
      tick();
      freeze = 1'b1;
      step   = 1'b1;
      for (int n = 3; n <= 12; n++) begin
         if (n == 3) begin
            wr_en   = 1'b1;
            wr_idx  = 4'(s);
            wr_data = new_val;
         end
         tick();
         if (n == 3) begin
            wr_en        = 1'b0;
            model_buf[s] = new_val;
            model_wr[s]  = 1'b1;
         end
         if (n == 6) step = 1'b0;
         compares++;
         if (sel_idx !== 4'(s) || disp !== old_val || blank !== old_blank) begin
            mismatches++;
            $display("FAIL freeze_hold n=%0d: got %0d/%h/%b expected %0d/%h/%b",
                     n, sel_idx, disp, blank, s, old_val, old_blank);
         end
      end
      freeze = 1'b0;
      tick();
      compares++;
      if (disp !== new_val || blank !== 4'b0000 || sel_idx !== 4'(s)) begin
         mismatches++;
         $display("FAIL freeze_release: got %h/%b/%0d expected %h/0000/%0d",
                  disp, blank, sel_idx, new_val, s);
      end
      tick();
      compares++;
      if (sel_idx !== 4'((s + 1) % N)) begin
         mismatches++;
         $display("FAIL freeze_counter_kept: got %0d expected %0d", sel_idx, (s + 1) % N);
      end
      auto_en = 1'b0;
      tick();
      model_sel = (s + 1) % N;
   endtask

   task automatic test_reset_midrun();
      auto_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
      end
      #3;
      reset_n = 1'b0;
      #1;
      compares++;
      if (sel_idx !== 4'd0 || blank !== 4'b1111 || disp !== 16'h0000) begin
         mismatches++;
         $display("FAIL reset_async: got %0d/%b/%h expected 0/1111/0000", sel_idx, blank, disp);
      end
      auto_en = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      clear_model();
      tick();
      compares++;
      if (sel_idx !== 4'd0 || blank !== 4'b1111 || disp !== 16'h0000) begin
         mismatches++;
         $display("FAIL reset_midrun: got %0d/%b/%h expected 0/1111/0000", sel_idx, blank, disp);
      end
   endtask

   // Random writes to even indices (some out of range); odd entries stay dark.
   task automatic test_random_writes();
      int s0;
      int e;
      int idx;
      int len;
      logic [15:0] d;
      logic [3:0]  exp_blank;
      for (int i = 0; i < 30; i++) begin
         idx = $urandom_range(0, 7) * 2;
         d   = 16'($urandom);
         do_write(idx, d);
         if (i % 5 == 0) do_write(idx, ~d);
      end
      tick();
      s0  = model_sel;
      len = 2 * N * DW + 3;
      auto_en = 1'b1;
      for (int n = 1; n <= len; n++) begin
         tick();
         e = (s0 + (n - 1) / DW) % N;
         exp_blank = model_wr[e] ? 4'b0000 : 4'b1111;
         compares++;
         if (sel_idx !== 4'((s0 + n / DW) % N)) begin
            mismatches++;
            $display("FAIL rand_sel n=%0d: got %0d expected %0d", n, sel_idx, (s0 + n / DW) % N);
         end
         compares++;
         if (disp !== model_buf[e] || blank !== exp_blank) begin
            mismatches++;
            $display("FAIL rand_disp n=%0d entry %0d: got %h/%b expected %h/%b",
                     n, e, disp, blank, model_buf[e], exp_blank);
         end
      end
      auto_en = 1'b0;
      tick();
      model_sel = (s0 + len / DW) % N;
   endtask

   initial begin
      compares   = 0;
      mismatches = 0;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = 4'd0;
      wr_data = 16'h0000;
      auto_en = 1'b0;
      step    = 1'b0;
      freeze  = 1'b0;
      test_reset();
      test_write_display();
      test_invalid_write();
      test_auto_cycle();
      test_step_terminal();
      test_step_held();
      test_freeze();
      test_reset_midrun();
      test_random_writes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Upstream driver for the four hex digit decoders on the debug display.
- Holds a small snapshot buffer of 16-bit DCPU-16 words (registers A..J, PC, SP, EX, IA), written over the CPU debug bus.
- Selects one entry for display, either by auto-cycling on a dwell timer or by manual push-button stepping.
- Presents the selected word as four registered nibbles plus per-digit blank flags, one nibble per decoder instance.

Parameters:
- NUM_REGS, 12, number of snapshot entries; any value 2..16, power of two not required.
- DWELL, 50_000_000, clock cycles each entry is shown in auto mode; minimum 2.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_REGS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for one cycle; writes wr_data into entry wr_idx.
- wr_idx  in  IDX_W  write index; if wr_idx >= NUM_REGS, the write is ignored.
- wr_data  in  16  word to store.
- auto_en  in  1  level; 1 = advance on the dwell timer.
- step  in  1  asynchronous push-button level, active high; each rising edge advances one entry.
- freeze  in  1  level; 1 = hold the displayed word, selection and timer.
- nib0  out  4  bits [3:0] of the displayed word (rightmost digit).
- nib1  out  4  bits [7:4].
- nib2  out  4  bits [11:8].
- nib3  out  4  bits [15:12].
- blank  out  4  per digit, 1 = digit dark; bit i corresponds to nib i.
- sel_idx  out  IDX_W  index of the entry currently shown.

Behaviour:
- Clock and reset:
  - Single clock domain; all state is reset asynchronously by reset_n low.
  - Reset values: all buffer entries 0; all written flags 0; sel_idx 0; dwell counter 0; nib0..nib3 0; blank 4'b1111; step synchroniser and edge registers 0.
  - Reset mid-operation discards all content; nothing survives.
- Buffer writes:
  - Entry wr_idx and its written flag are updated at the clock edge where wr_en=1.
  - Writes are accepted regardless of freeze and auto_en.
  - Back-to-back writes are allowed, one per cycle; writing the same index twice keeps the last value.
- Display register:
  - Every edge with freeze=0, nib0..nib3 load from entry sel_idx (as it was before that edge).
  - blank loads 4'b0000 if that entry's written flag is set, else 4'b1111.
  - Latency from write to display:
    - wr_en at edge k targeting the shown index: new nibbles are visible after edge k+1.
    - After a sel_idx change at edge k: the new entry is visible after edge k+1.
  - With freeze=1, the nibbles, blank, sel_idx and dwell counter all hold.
  - On freeze falling, the display refreshes from the buffer at the next edge.
- Step input:
  - Path: 2-flop synchroniser, then a rising-edge detector.
  - The detected pulse is 1 cycle wide, 3 edges after the step rise.
  - Holding step high produces exactly one advance.
  - Edges detected while freeze=1 are dropped, not queued.
- Selection state (two states):
  - MANUAL (auto_en=0):
    - Dwell counter held at 0.
    - A step pulse sets sel_idx to (sel_idx+1) mod NUM_REGS.
  - AUTO (auto_en=1):
    - Counter counts 0..DWELL-1.
    - At terminal count, sel_idx advances by 1 mod NUM_REGS and the counter returns to 0.
    - A step pulse also advances sel_idx and clears the counter.
  - Transitions:
    - auto_en 1->0: counter cleared at the next edge.
    - auto_en 0->1: counting starts from 0.
  - A step pulse coinciding with terminal count advances exactly one entry.
- Wrap-around: sel_idx NUM_REGS-1 -> 0, including non-power-of-two NUM_REGS; sel_idx never reaches NUM_REGS or above.
- Blanking:
  - No leading-zero suppression; all four digits of a written entry are lit.
  - The decoders see nibble 0 while blank=1; top level gates segments off with blank.

Decomposition:
- Package hex_disp_pkg:
  - DATA_W = 16.
  - NUM_REGS and DWELL defaults.
  - idx_t typedef (logic [IDX_W-1:0]).
  - Named index constants IDX_A..IDX_IA matching the CPU register numbering.
- One sub-module, btn_edge_sync: 2-flop synchroniser plus rising-edge pulse, with clk/reset_n.
- Remaining logic (buffer, timer, selection, output register) stays in hex_display_ctrl.
- Top level instantiates four SEG_HEX decoders on nib0..nib3.

Test Plan:
- Reset: assert reset_n=0 mid-count with entries written, release -> blank=4'b1111, nibs 0, sel_idx 0, all entries read back unwritten.
- Write/display, NUM_REGS=12, DWELL=4, auto_en=0: write 16'hBEEF to idx 0 at edge k -> after edge k+1 nib3..nib0 = B,E,E,F and blank=0000.
- Write to idx 12: write 16'h1234 -> ignored; no entry or flag changes.
- Auto cycle, DWELL=4: auto_en=1 with entries 0..11 = 16'h0100+i -> sel_idx advances every 4 cycles; 11 wraps to 0; entry 3 shows 0,1,0,3.
- Step and freeze:
  - Step pulse coinciding with terminal count -> sel_idx +1 only.
  - Step held high 20 cycles -> one advance.
  - freeze=1 with a step edge and a write to the shown index -> display, sel_idx and counter unchanged.
  - freeze released -> new data shown after one edge.
- Unwritten entry: auto-cycle onto an entry never written -> blank=1111 for its dwell period; blank returns to 0000 on a written entry.
